// File: rtl/alu_seq.sv
// Sequencer that runs one ALU operation over a 4 x 4-bit register file and
// updates the architectural flags. Optional feature macro: ALU_SEQ_CARRY_CHAIN_EN.
//
// state | meaning
// IDLE  | waiting for start; direct register loads accepted
// READ  | operands presented on alu_*; command reloaded from latched fields
// EXEC  | alu_* held; result and flags captured at end of cycle
// WB    | result written to reg[rd], flags committed, done pulsed
module alu_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [1:0] rs,
  input  logic [1:0] rt,
  input  logic [1:0] rd,
`ifdef ALU_SEQ_CARRY_CHAIN_EN
  input  logic       use_cf,
`endif
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [1:0] rd_addr,
  output logic [3:0] rd_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_r,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_sign,
  output logic       busy,
  output logic       done,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_s
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t     state;
  logic [3:0] regs [4];

  logic [2:0] cmd_op;
  logic [1:0] cmd_rs;
  logic [1:0] cmd_rt;
  logic [1:0] cmd_rd;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
  logic       cmd_use_cf;
`endif

  logic [3:0] res_q;
  logic       stg_z;
  logic       stg_c;
  logic       stg_s;

  logic [3:0] src_a;
  logic [3:0] src_b;
  logic       start_cin;
  logic       read_cin;

  assign rd_data = regs[rd_addr];

  // A direct load committing on the start edge must be seen by the operands.
  assign src_a = (wr_en && (wr_addr == rs)) ? wr_data : regs[rs];
  assign src_b = (wr_en && (wr_addr == rt)) ? wr_data : regs[rt];

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  assign start_cin = use_cf & flag_c;
  assign read_cin  = cmd_use_cf & flag_c;
`else
  assign start_cin = 1'b0;
  assign read_cin  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      cmd_op <= '0;
      cmd_rs <= '0;
      cmd_rt <= '0;
      cmd_rd <= '0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      cmd_use_cf <= 1'b0;
`endif
      res_q   <= '0;
      stg_z   <= 1'b0;
      stg_c   <= 1'b0;
      stg_s   <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      alu_cin <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_s  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) regs[wr_addr] <= wr_data;
          if (start) begin
            state  <= READ;
            busy   <= 1'b1;
            cmd_op <= op;
            cmd_rs <= rs;
            cmd_rt <= rt;
            cmd_rd <= rd;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
            cmd_use_cf <= use_cf;
`endif
            // Operands go out on the start edge so the ALU settles during READ.
            alu_a   <= src_a;
            alu_b   <= src_b;
            alu_op  <= op;
            alu_cin <= start_cin;
          end
        end
        READ: begin
          // Registers and flags cannot change while busy, so this reload
          // reproduces the values presented on the start edge.
          alu_a   <= regs[cmd_rs];
          alu_b   <= regs[cmd_rt];
          alu_op  <= cmd_op;
          alu_cin <= read_cin;
          state   <= EXEC;
        end
        EXEC: begin
          res_q <= alu_r;
          stg_z <= alu_zero;
          stg_c <= alu_carry;
          stg_s <= alu_sign;
          done  <= 1'b1;
          state <= WB;
        end
        WB: begin
          regs[cmd_rd] <= res_q;
          flag_z <= stg_z;
          flag_c <= stg_c;
          flag_s <= stg_s;
          done   <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq with a behavioural ALU and a
// register-file/flag reference model.
module tb_alu_seq;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [1:0] rs = '0, rt = '0, rd = '0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
  logic       use_cf = 1'b0;
`endif
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [1:0] rd_addr = '0;
  logic [3:0] rd_data;
  logic [3:0] alu_a, alu_b, alu_r;
  logic       alu_cin;
  logic [2:0] alu_op;
  logic       alu_zero, alu_carry, alu_sign;
  logic       busy, done, flag_z, flag_c, flag_s;

  int n_checks = 0;
  int n_pass = 0;

  logic [3:0] m_regs [4];
  logic       m_z = 1'b0, m_c = 1'b0, m_s = 1'b0;

  alu_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .rs(rs), .rt(rt), .rd(rd),
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    .use_cf(use_cf),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign),
    .busy(busy), .done(done), .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s)
  );

  always #5 clk = ~clk;

  // Returns {carry, result} using plain integer arithmetic.
  function automatic logic [4:0] alu_fn(input logic [2:0] o, input logic [3:0] a,
                                        input logic [3:0] b, input logic cin);
    int s;
    case (o)
      3'd0: s = int'(a) + int'(b) + int'(cin);
      3'd1: s = (int'(a) - int'(b) - int'(cin)) & 31;
      3'd2: s = int'(a & b);
      3'd3: s = int'(a | b);
      3'd4: s = int'(a ^ b);
      3'd5: s = int'(a) * 2;
      3'd6: s = 15 - int'(a);
      default: s = int'(b);
    endcase
    return 5'(s);
  endfunction

  logic [4:0] alu_out;
  always_comb begin
    alu_out   = alu_fn(alu_op, alu_a, alu_b, alu_cin);
    alu_r     = alu_out[3:0];
    alu_carry = alu_out[4];
    alu_zero  = (alu_out[3:0] == 4'h0);
    alu_sign  = alu_out[3];
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      check($sformatf("%s_reg%0d", tag, i), 8'(rd_data), 8'(m_regs[i]));
    end
    check({tag, "_flags"}, {5'b0, flag_z, flag_c, flag_s}, {5'b0, m_z, m_c, m_s});
  endtask

  task automatic load(input logic [1:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] rdst, input logic ucf, input logic byp,
                       input logic [1:0] baddr, input logic [3:0] bdata, input logic noise);
    logic [3:0] ea, eb;
    logic       ecin;
    logic [4:0] res;
    op = o; rs = ra; rt = rb; rd = rdst; start = 1'b1;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    use_cf = ucf;
`endif
    wr_en = byp; wr_addr = baddr; wr_data = bdata;
    if (byp) m_regs[baddr] = bdata;
    ea = m_regs[ra];
    eb = m_regs[rb];
    ecin = CC ? (ucf & m_c) : 1'b0;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    check("read_busy", 8'(busy), 8'd1);
    check("read_done", 8'(done), 8'd0);
    check("read_alu_a", 8'(alu_a), 8'(ea));
    check("read_alu_b", 8'(alu_b), 8'(eb));
    check("read_alu_op", 8'(alu_op), 8'(o));
    check("read_alu_cin", 8'(alu_cin), 8'(ecin));
    if (noise) begin
      start = 1'b1; wr_en = 1'b1;
      wr_addr = 2'($urandom); wr_data = 4'($urandom);
      op = 3'($urandom); rs = 2'($urandom); rt = 2'($urandom); rd = 2'($urandom);
    end
    @(posedge clk); #1;
    check("exec_alu_a", 8'(alu_a), 8'(ea));
    check("exec_alu_b", 8'(alu_b), 8'(eb));
    check("exec_alu_cin", 8'(alu_cin), 8'(ecin));
    check("exec_done", 8'(done), 8'd0);
    @(posedge clk); #1;
    check("wb_done", 8'(done), 8'd1);
    check("wb_busy", 8'(busy), 8'd1);
    start = 1'b0; wr_en = 1'b0;
    res = alu_fn(o, ea, eb, ecin);
    @(posedge clk); #1;
    m_regs[rdst] = res[3:0];
    m_z = (res[3:0] == 4'h0);
    m_c = res[4];
    m_s = res[3];
    check("idle_done", 8'(done), 8'd0);
    check("idle_busy", 8'(busy), 8'd0);
    check_state("after_op");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_alu_a", 8'(alu_a), 8'd0);
    check("rst_alu_cin", 8'(alu_cin), 8'd0);
    check_state("rst");
    reset_n = 1'b1;

    // First edge after release accepts start: 0+0 sets Z.
    do_op(3'd0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);

    // Latency / basic add: 3 + 4 -> 7.
    load(2'd1, 4'h3);
    load(2'd2, 4'h4);
    do_op(3'd0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);

    // Zero with carry: 8 + 8; then a direct load must not touch flags.
    load(2'd0, 4'h8);
    do_op(3'd0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    load(2'd3, 4'h5);
    check_state("load_keeps_flags");

    // Carry chain with flag_c = 1, then with use_cf = 0.
    do_op(3'd0, 2'd3, 2'd1, 2'd1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    do_op(3'd0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    do_op(3'd0, 2'd3, 2'd3, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);

    // Bypass of a same-cycle direct load into operand A.
    do_op(3'd2, 2'd1, 2'd3, 2'd0, 1'b0, 1'b1, 2'd1, 4'hA, 1'b0);

    // Start/wr_en pulsed while busy; rd equal to a source.
    do_op(3'd4, 2'd1, 2'd2, 2'd1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) load(2'($urandom), 4'($urandom));
      do_op(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
            1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom));
    end

    // Make sure flags are nonzero before the abort test.
    load(2'd0, 4'hF);
    do_op(3'd0, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);

    // Abort mid-EXEC.
    op = 3'd0; rs = 2'd3; rt = 2'd3; rd = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
    m_z = 1'b0; m_c = 1'b0; m_s = 1'b0;
    check("abort_busy", 8'(busy), 8'd0);
    check("abort_done", 8'(done), 8'd0);
    check_state("abort");
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", 8'(done), 8'd0);
    end
    check_state("abort_after");
    do_op(3'd6, 2'd2, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameters: none; data width fixed at 4 bits, register file fixed at 4 entries.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request one ALU operation; sampled only in IDLE.
REQ-005 op  in  3  ALU operation code, forwarded unchanged to alu_op.
REQ-006 rs, rt  in  2 each  source register indices for operands A and B.
REQ-007 rd  in  2  destination register index.
REQ-008 use_cf  in  1  carry-in select: 1 selects flag_c, 0 selects constant 0 (see Configuration).
REQ-009 wr_en, wr_addr, wr_data  in  1/2/4  direct register load port.
REQ-010 rd_addr  in  2; rd_data  out  4  combinational debug read of the register file.
REQ-011 alu_a, alu_b  out  4; alu_cin  out  1; alu_op  out  3  registered drive to the ALU.
REQ-012 alu_r  in  4; alu_zero, alu_carry, alu_sign  in  1  ALU result and flags, combinational from alu_* outputs.
REQ-013 busy  out  1  high in every state other than IDLE.
REQ-014 done  out  1  one-cycle pulse in WB.
REQ-015 flag_z, flag_c, flag_s  out  1  architectural flags register.

Function
REQ-016 FSM states: IDLE, READ, EXEC, WB; IDLE->READ when start=1; READ->EXEC->WB->IDLE unconditionally.
REQ-017 On start in IDLE: latch op, rs, rt, rd, use_cf into command registers.
REQ-018 READ: load alu_a=reg[rs], alu_b=reg[rt], alu_op=op, alu_cin=(use_cf ? flag_c : 0), values as of the end of the start cycle.
REQ-019 EXEC: alu_* held stable; capture alu_r into a 4-bit result register and alu_zero/carry/sign into a flag staging register at end of EXEC.
REQ-020 WB: write result to reg[rd]; copy staged flags to flag_z/c/s; done=1 for exactly this cycle.
REQ-021 Latency: start sampled at edge t -> done high in cycle t+3 -> reg[rd] and flags visible at t+4; throughput one operation per 4 cycles.
REQ-022 start while busy=1 is ignored, not queued.
REQ-023 wr_en acts only in IDLE; ignored when busy=1.
REQ-024 wr_en and start in same IDLE cycle: direct write commits at that edge; READ uses the new value if wr_addr equals rs or rt.
REQ-025 rd equal to rs or rt is legal; source values already latched, writeback overwrites.
REQ-026 alu_* outputs hold last values in IDLE; no flag or register update outside WB or direct load.
REQ-027 Direct loads do not alter flags.

Reset
REQ-028 reset_n=0 forces immediately: state IDLE, all 4 registers 0, flags 0, alu_a/alu_b/alu_op/alu_cin 0, command/result/staging registers 0, busy 0, done 0.
REQ-029 Reset asserted mid-operation aborts: no writeback, no flag update, no done pulse after release.
REQ-030 First start accepted on the first rising edge with reset_n=1.

Configuration
REQ-031 Macro ALU_SEQ_CARRY_CHAIN_EN defined: use_cf port present, alu_cin per REQ-018.
REQ-032 Macro undefined: use_cf port absent, alu_cin constant 0, flag_c still updated from alu_carry.

Verification
REQ-033 Reset: drive reset_n=0 mid-EXEC -> busy=0, done=0, flags=0, rd_data=0 for all rd_addr, no later done.
REQ-034 Latency: load reg1=4'h3, reg2=4'h4, start rs=1 rt=2 rd=3; bench ALU returns 4'h7, carry 0 -> done at t+3, alu_a=3, alu_b=4, reg3=7, flag_z=0, flag_s=0.
REQ-035 Flags: ALU returns 4'h0, carry 1 -> flag_z=1, flag_c=1, flag_s=0 after WB; subsequent direct load leaves flags unchanged.
REQ-036 Carry chain (macro on): flag_c=1, start use_cf=1 -> alu_cin=1 in READ/EXEC; use_cf=0 -> alu_cin=0; macro off -> alu_cin always 0.
REQ-037 Busy rules: start and wr_en pulsed during READ/EXEC/WB -> ignored, only one done, target register unchanged by wr_en.
REQ-038 Bypass: wr_en wr_addr=1 wr_data=4'hA with start rs=1 same cycle -> alu_a=4'hA in EXEC.
